// File: rtl/tcp_msg_poller_engine.sv
// Round-robin poller: reads each flow's message request and payload pointers,
// and notifies the requesting tile once enough payload bytes are buffered.
package tcp_msg_poller_pkg;
    localparam int REQ_PTR_W       = 8;
    localparam int XY_WIDTH        = 8;
    localparam int NOC_FBITS_WIDTH = 4;

    typedef struct packed {
        logic [REQ_PTR_W-1:0]       length;
        logic [XY_WIDTH-1:0]        dst_x;
        logic [XY_WIDTH-1:0]        dst_y;
        logic [NOC_FBITS_WIDTH-1:0] dst_fbits;
    } msg_req_mem_struct;

    localparam int MSG_REQ_MEM_STRUCT_W = $bits(msg_req_mem_struct);
endpackage

module tcp_msg_poller_engine
    import tcp_msg_poller_pkg::*;
#(
    parameter int NUM_FLOWS = 8,
    parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            poll_en,

    output logic                            req_rd_val,
    output logic [FLOWID_W-1:0]             req_rd_addr,
    input  logic                            req_rd_rdy,
    input  logic                            req_rd_resp_val,
    input  logic                            req_rd_resp_pending,
    input  logic [MSG_REQ_MEM_STRUCT_W-1:0] req_rd_resp_data,

    output logic                            ptr_rd_val,
    output logic [FLOWID_W-1:0]             ptr_rd_addr,
    input  logic                            ptr_rd_rdy,
    input  logic                            ptr_rd_resp_val,
    input  logic [REQ_PTR_W:0]              ptr_rd_resp_head,
    input  logic [REQ_PTR_W:0]              ptr_rd_resp_tail,

    output logic                            clr_val,
    output logic [FLOWID_W-1:0]             clr_addr,
    input  logic                            clr_rdy,

    output logic                            notif_val,
    input  logic                            notif_rdy,
    output logic [FLOWID_W-1:0]             notif_flowid,
    output logic [REQ_PTR_W-1:0]            notif_length,
    output logic [REQ_PTR_W:0]              notif_ptr,
    output logic [XY_WIDTH-1:0]             notif_dst_x,
    output logic [XY_WIDTH-1:0]             notif_dst_y,
    output logic [NOC_FBITS_WIDTH-1:0]      notif_dst_fbits
);

    typedef enum logic [1:0] {ISSUE, WAIT, EVAL, NOTIFY} state_t;

    state_t              state_reg, state_next;
    logic [FLOWID_W-1:0] cur_flow_reg, cur_flow_next, cur_flow_inc;
    logic                req_got_reg, ptr_got_reg;
    logic                pending_reg;
    msg_req_mem_struct   entry_reg;
    logic [REQ_PTR_W:0]  head_reg, tail_reg;
    logic                notif_done_reg, clr_done_reg;
    logic [REQ_PTR_W:0]  avail;
    logic                hit;

    // Pointers carry a wrap bit, so plain subtraction at full width gives occupancy.
    assign avail = tail_reg - head_reg;
    assign hit   = pending_reg && (entry_reg.length != '0) &&
                   (avail >= {1'b0, entry_reg.length});

    assign cur_flow_inc = (cur_flow_reg == FLOWID_W'(NUM_FLOWS - 1)) ?
                          '0 : cur_flow_reg + FLOWID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ISSUE;
            cur_flow_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cur_flow_reg <= cur_flow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_flow_next = cur_flow_reg;
        req_rd_val    = 1'b0;
        ptr_rd_val    = 1'b0;
        notif_val     = 1'b0;
        clr_val       = 1'b0;
        case (state_reg)
            ISSUE: begin
                // Reset state is ISSUE; keep the read strobes quiet while held in reset.
                req_rd_val = poll_en && rst_n;
                ptr_rd_val = poll_en && rst_n;
                if (poll_en && req_rd_rdy && ptr_rd_rdy)
                    state_next = WAIT;
            end
            WAIT: begin
                if ((req_got_reg || req_rd_resp_val) && (ptr_got_reg || ptr_rd_resp_val))
                    state_next = EVAL;
            end
            EVAL: begin
                if (hit) begin
                    state_next = NOTIFY;
                end else begin
                    state_next    = ISSUE;
                    cur_flow_next = cur_flow_inc;
                end
            end
            NOTIFY: begin
                notif_val = !notif_done_reg;
                clr_val   = !clr_done_reg;
                if ((notif_done_reg || notif_rdy) && (clr_done_reg || clr_rdy)) begin
                    state_next    = ISSUE;
                    cur_flow_next = cur_flow_inc;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_got_reg    <= 1'b0;
            ptr_got_reg    <= 1'b0;
            pending_reg    <= 1'b0;
            entry_reg      <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            notif_done_reg <= 1'b0;
            clr_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ISSUE: begin
                    req_got_reg <= 1'b0;
                    ptr_got_reg <= 1'b0;
                end
                WAIT: begin
                    if (req_rd_resp_val && !req_got_reg) begin
                        req_got_reg <= 1'b1;
                        pending_reg <= req_rd_resp_pending;
                        entry_reg   <= req_rd_resp_data;
                    end
                    if (ptr_rd_resp_val && !ptr_got_reg) begin
                        ptr_got_reg <= 1'b1;
                        head_reg    <= ptr_rd_resp_head;
                        tail_reg    <= ptr_rd_resp_tail;
                    end
                end
                EVAL: begin
                    notif_done_reg <= 1'b0;
                    clr_done_reg   <= 1'b0;
                end
                NOTIFY: begin
                    if (notif_val && notif_rdy) notif_done_reg <= 1'b1;
                    if (clr_val && clr_rdy)     clr_done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_rd_addr     = cur_flow_reg;
    assign ptr_rd_addr     = cur_flow_reg;
    assign clr_addr        = cur_flow_reg;
    assign notif_flowid    = cur_flow_reg;
    assign notif_length    = entry_reg.length;
    assign notif_ptr       = head_reg;
    assign notif_dst_x     = entry_reg.dst_x;
    assign notif_dst_y     = entry_reg.dst_y;
    assign notif_dst_fbits = entry_reg.dst_fbits;

endmodule
